// File: rtl/ads_pkg.sv
// Shared types and constants for the ADS8568 frame receiver.
package ads_pkg;

    localparam int ADS_LANES         = 4;
    localparam int ADS_CHANNELS      = 8;
    localparam int ADS_BITS_PER_LANE = 32;
    localparam int ADS_SAMPLE_W      = 16;
    localparam int ADS_FRAME_W       = ADS_CHANNELS * ADS_SAMPLE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT_BH,
        ST_WAIT_BL,
        ST_SYNC,
        ST_SHIFT,
        ST_HOLD
    } ads_state_e;

    typedef logic [ADS_LANES-1:0][ADS_BITS_PER_LANE-1:0] ads_lanes_t;

    // Lane k carries channel 2k in its upper half and channel 2k+1 in its lower half.
    function automatic logic [ADS_FRAME_W-1:0] pack_frame(input ads_lanes_t lanes);
        logic [ADS_FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < ADS_LANES; k++) begin
            f[32*k +: 32] = {lanes[k][15:0], lanes[k][31:16]};
        end
        return f;
    endfunction

endpackage

// File: rtl/ads_sclk_gen.sv
// Serial clock generator: SCLK_DIV cycles high, SCLK_DIV cycles low, idle low.
// rise/fall flag the cycle in which ad_sclk is driven low->high / high->low.
module ads_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic last,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

    logic [3:0] div_cnt;

    assign rise = run && !sclk && (div_cnt == 4'd0);
    assign fall = run &&  sclk && (div_cnt == 4'd0);

    // last parks the clock low on the closing strobe so no 33rd pulse appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk    <= 1'b0;
            div_cnt <= 4'd0;
        end else if (!run) begin
            sclk    <= 1'b0;
            div_cnt <= 4'd0;
        end else if (rise) begin
            if (!last) begin
                sclk    <= 1'b1;
                div_cnt <= DIV_LAST;
            end
        end else if (fall) begin
            sclk    <= 1'b0;
            div_cnt <= DIV_LAST;
        end else begin
            div_cnt <= div_cnt - 4'd1;
        end
    end

endmodule

// File: rtl/ads_frame_rx.sv
// ADS8568 4-lane serial frame receiver producing one 8x16-bit frame per conversion.
// Optional busy watchdog enabled by defining ADS_BUSY_TIMEOUT_EN.
module ads_frame_rx
    import ads_pkg::*;
#(
    parameter int SCLK_DIV        = 2,
    parameter int CONVST_W        = 4,
    parameter int WATCH_DOG_WIDTH = 12
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   trig_convst,
    output logic                   ad_convst,
    input  logic                   ad_busy,
    output logic                   ad_fs_n,
    output logic                   ad_sclk,
    input  logic [ADS_LANES-1:0]   ad_sdo,
    output logic [ADS_FRAME_W-1:0] frm_tdata,
    output logic                   frm_tvalid,
    input  logic                   frm_tready,
    output logic                   frm_drop,
    output logic                   frm_err,
    output ads_state_e             fsm_state
);

    localparam logic [4:0] CONV_LAST = 5'(CONVST_W - 1);
    localparam logic [4:0] BIT_LAST  = 5'(ADS_BITS_PER_LANE - 1);

    ads_state_e state;
    logic [4:0] bit_cnt;
    logic       tail;
    ads_lanes_t sh;
    logic       run;
    logic       rise;
    logic       fall;

`ifdef ADS_BUSY_TIMEOUT_EN
    localparam logic [WATCH_DOG_WIDTH-1:0] WD_LAST = {{(WATCH_DOG_WIDTH-1){1'b1}}, 1'b0};
    logic [WATCH_DOG_WIDTH-1:0] wd_cnt;
`else
    assign frm_err = 1'b0;
`endif

    assign fsm_state = state;
    assign run       = (state == ST_SYNC) || (state == ST_SHIFT);

    ads_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .run   (run),
        .last  (tail),
        .sclk  (ad_sclk),
        .rise  (rise),
        .fall  (fall)
    );

    // Output handshake: a frame transfers on a cycle with frm_tvalid && frm_tready;
    // frm_tdata/frm_tvalid never change while frm_tvalid is high and frm_tready is low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 5'd0;
            tail       <= 1'b0;
            sh         <= '0;
            ad_convst  <= 1'b0;
            ad_fs_n    <= 1'b1;
            frm_tdata  <= '0;
            frm_tvalid <= 1'b0;
            frm_drop   <= 1'b0;
`ifdef ADS_BUSY_TIMEOUT_EN
            frm_err    <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            frm_drop <= trig_convst && (state != ST_IDLE);
`ifdef ADS_BUSY_TIMEOUT_EN
            frm_err  <= 1'b0;
`endif
            if (rise && !tail) begin
                for (int k = 0; k < ADS_LANES; k++) begin
                    sh[k] <= {sh[k][ADS_BITS_PER_LANE-2:0], ad_sdo[k]};
                end
            end
            case (state)
                ST_IDLE: begin
                    if (trig_convst) begin
                        state     <= ST_CONV;
                        ad_convst <= 1'b1;
                        bit_cnt   <= 5'd0;
                    end
                end
                ST_CONV: begin
                    if (bit_cnt == CONV_LAST) begin
                        state     <= ST_WAIT_BH;
                        ad_convst <= 1'b0;
                        bit_cnt   <= 5'd0;
`ifdef ADS_BUSY_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                ST_WAIT_BH: begin
                    if (ad_busy) begin
                        state <= ST_WAIT_BL;
`ifdef ADS_BUSY_TIMEOUT_EN
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        state   <= ST_IDLE;
                        frm_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                ST_WAIT_BL: begin
                    if (!ad_busy) begin
                        state   <= ST_SYNC;
                        ad_fs_n <= 1'b0;
`ifdef ADS_BUSY_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        state   <= ST_IDLE;
                        frm_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                ST_SYNC: begin
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // bit_cnt counts completed sclk periods; tail marks the final low phase.
                    if (fall) begin
                        if (bit_cnt == BIT_LAST) begin
                            tail <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    if (rise && tail) begin
                        state      <= ST_HOLD;
                        tail       <= 1'b0;
                        bit_cnt    <= 5'd0;
                        ad_fs_n    <= 1'b1;
                        frm_tdata  <= pack_frame(sh);
                        frm_tvalid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (frm_tready) begin
                        state      <= ST_IDLE;
                        frm_tvalid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ads_frame_rx.sv
// Directed self-checking bench for ads_frame_rx with a behavioural ADS8568 lane driver.
module tb_ads_frame_rx;
    import ads_pkg::*;

    localparam int SCLK_DIV = 2;

    localparam logic [127:0] EXP1 = 128'h3002_3001_2002_2001_1002_1001_0002_0001;
    localparam logic [127:0] EXP2 = 128'h0000_FFFF_5A5A_A5A5_5678_1234_BEEF_DEAD;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         trig_convst = 1'b0;
    logic         ad_busy = 1'b0;
    logic [3:0]   ad_sdo = 4'h0;
    logic         frm_tready = 1'b0;
    logic         ad_convst;
    logic         ad_fs_n;
    logic         ad_sclk;
    logic [127:0] frm_tdata;
    logic         frm_tvalid;
    logic         frm_drop;
    logic         frm_err;
    ads_state_e   fsm_state;

    int checks = 0;
    int errors = 0;

    ads_lanes_t f1 = {32'h3001_3002, 32'h2001_2002, 32'h1001_1002, 32'h0001_0002};
    ads_lanes_t f2 = {32'hFFFF_0000, 32'hA5A5_5A5A, 32'h1234_5678, 32'hDEAD_BEEF};

    always #5 sys_clk = ~sys_clk;

    ads_frame_rx #(.SCLK_DIV(SCLK_DIV), .CONVST_W(4), .WATCH_DOG_WIDTH(12)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .trig_convst (trig_convst),
        .ad_convst   (ad_convst),
        .ad_busy     (ad_busy),
        .ad_fs_n     (ad_fs_n),
        .ad_sclk     (ad_sclk),
        .ad_sdo      (ad_sdo),
        .frm_tdata   (frm_tdata),
        .frm_tvalid  (frm_tvalid),
        .frm_tready  (frm_tready),
        .frm_drop    (frm_drop),
        .frm_err     (frm_err),
        .fsm_state   (fsm_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_convst"}, ad_convst, 1'b0);
        check({tag, "_fs_n"}, ad_fs_n, 1'b1);
        check({tag, "_sclk"}, ad_sclk, 1'b0);
        check({tag, "_tvalid"}, frm_tvalid, 1'b0);
        check({tag, "_tdata"}, frm_tdata, 128'h0);
        check({tag, "_drop"}, frm_drop, 1'b0);
        check({tag, "_err"}, frm_err, 1'b0);
        check({tag, "_state"}, fsm_state, ST_IDLE);
    endtask

    // Plays the ADC: pulses trig, answers with busy, shifts lane data out MSB first
    // after fs_n falls and after every sclk falling edge. Returns at the first
    // negedge with fs_n high again (or right after applying reset when aborting).
    task automatic drive_frame(input ads_lanes_t lv, input int busy_cycles, input int abort_after,
                               output int convst_len, output int fs_len,
                               output int pulses, output int bad_periods);
        int  idx;
        int  cyc;
        int  last_rise;
        logic prev_sclk;
        bit  done;
        convst_len = 0; fs_len = 0; pulses = 0; bad_periods = 0;
        @(negedge sys_clk); trig_convst = 1'b1;
        @(negedge sys_clk); trig_convst = 1'b0;
        cyc = 0;
        while (ad_convst === 1'b1 && cyc < 100) begin
            convst_len++; cyc++;
            @(negedge sys_clk);
        end
        ad_busy = 1'b1;
        repeat (busy_cycles) @(negedge sys_clk);
        ad_busy = 1'b0;
        cyc = 0;
        while (ad_fs_n !== 1'b0 && cyc < 100) begin
            cyc++;
            @(negedge sys_clk);
        end
        idx = 31;
        for (int k = 0; k < 4; k++) ad_sdo[k] = lv[k][idx];
        prev_sclk = 1'b0; last_rise = -1; cyc = 0; done = 1'b0;
        while (ad_fs_n === 1'b0 && cyc < 400 && !done) begin
            fs_len++;
            if (ad_sclk === 1'b1 && prev_sclk === 1'b0) begin
                if (last_rise >= 0 && (cyc - last_rise) != 2 * SCLK_DIV) bad_periods++;
                last_rise = cyc;
                pulses++;
                if (pulses == abort_after) begin
                    sys_rst_n = 1'b0;
                    done = 1'b1;
                end
            end
            if (ad_sclk === 1'b0 && prev_sclk === 1'b1 && idx > 0) begin
                idx--;
                for (int k = 0; k < 4; k++) ad_sdo[k] = lv[k][idx];
            end
            prev_sclk = ad_sclk;
            cyc++;
            if (!done) @(negedge sys_clk);
        end
    endtask

    initial begin
        int cl, fl, pl, bp;
        int cnt;
        int k;

        // Reset state
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Basic frame with timing measurements
        drive_frame(f1, 50, 0, cl, fl, pl, bp);
        check("convst_len", cl, 4);
        check("fs_low_len", fl, 129);
        check("sclk_pulses", pl, 32);
        check("sclk_period_bad", bp, 0);
        check("f1_fs_n_high", ad_fs_n, 1'b1);
        check("f1_sclk_low", ad_sclk, 1'b0);
        check("f1_tvalid", frm_tvalid, 1'b1);
        check("f1_tdata", frm_tdata, EXP1);
        check("f1_state", fsm_state, ST_HOLD);

        // Backpressure with a trigger arriving during HOLD
        for (int i = 0; i < 20; i++) begin
            trig_convst = (i == 5);
            @(negedge sys_clk);
            trig_convst = 1'b0;
            check("bp_tvalid", frm_tvalid, 1'b1);
            check("bp_tdata", frm_tdata, EXP1);
            if (i == 5) check("bp_drop", frm_drop, 1'b1);
            if (i == 6) check("bp_drop_once", frm_drop, 1'b0);
        end
        frm_tready = 1'b1;
        @(negedge sys_clk);
        frm_tready = 1'b0;
        check("hs_tvalid_low", frm_tvalid, 1'b0);
        check("hs_state", fsm_state, ST_IDLE);
        cnt = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (frm_tvalid === 1'b1 || ad_convst === 1'b1) cnt++;
        end
        check("no_second_frame", cnt, 0);

        // Second pattern; trigger coincides with the HOLD handshake
        drive_frame(f2, 10, 0, cl, fl, pl, bp);
        check("f2_fs_low_len", fl, 129);
        check("f2_tdata", frm_tdata, EXP2);
        frm_tready = 1'b1; trig_convst = 1'b1;
        @(negedge sys_clk);
        frm_tready = 1'b0; trig_convst = 1'b0;
        check("hs_trig_drop", frm_drop, 1'b1);
        check("hs_trig_tvalid", frm_tvalid, 1'b0);
        repeat (5) @(negedge sys_clk);
        check("hs_trig_state", fsm_state, ST_IDLE);
        check("hs_trig_convst", ad_convst, 1'b0);

        // Reset during bit 10 of the shift phase
        drive_frame(f2, 20, 10, cl, fl, pl, bp);
        check("abort_pulses", pl, 10);
        @(negedge sys_clk);
        check_reset_outputs("abort");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (frm_tvalid === 1'b1) cnt++;
        end
        check("abort_no_partial", cnt, 0);
        drive_frame(f1, 30, 0, cl, fl, pl, bp);
        check("f3_sclk_pulses", pl, 32);
        check("f3_tvalid", frm_tvalid, 1'b1);
        check("f3_tdata", frm_tdata, EXP1);
        frm_tready = 1'b1;
        @(negedge sys_clk);
        frm_tready = 1'b0;
        check("f3_idle", fsm_state, ST_IDLE);

        // Busy never rises
        @(negedge sys_clk); trig_convst = 1'b1;
        @(negedge sys_clk); trig_convst = 1'b0;
        cnt = 0;
        while (ad_convst === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge sys_clk);
        end
`ifdef ADS_BUSY_TIMEOUT_EN
        k = 1;
        while (frm_err !== 1'b1 && k < 6000) begin
            @(negedge sys_clk);
            k++;
        end
        check("wd_cycle", k, 4096);
        check("wd_err", frm_err, 1'b1);
        check("wd_state", fsm_state, ST_IDLE);
        @(negedge sys_clk);
        check("wd_err_once", frm_err, 1'b0);
        check("wd_no_frame", frm_tvalid, 1'b0);
`else
        k = 0;
        repeat (5000) begin
            @(negedge sys_clk);
            if (frm_err !== 1'b0) k++;
        end
        check("nowd_err", k, 0);
        check("nowd_state", fsm_state, ST_WAIT_BH);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("nowd_rst_state", fsm_state, ST_IDLE);
        sys_rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
